// File: rtl/multi_operand_cla_pipe.sv
// multi_operand_cla_pipe: pipelined balanced adder tree of 4-bit carry-lookahead adders
// with valid/ready flow control and optional saturation of the final result.
module multi_operand_cla_pipe_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W:0]   s
);
    localparam int G = (W + 3) / 4;
    localparam int GW = 4 * G;
    logic [GW-1:0] p, g, x;
    logic [G:0] c;
    assign p = GW'(a) ^ GW'(b);
    assign g = GW'(a) & GW'(b);
    assign c[0] = ci;
    genvar j;
    for (j = 0; j < G; j++) begin : grp
        logic [3:0] gp, gg;
        logic [4:0] gc;
        assign gp = p[4*j +: 4];
        assign gg = g[4*j +: 4];
        assign gc[0] = c[j];
        assign gc[1] = gg[0] | (gp[0] & gc[0]);
        assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
        assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                     | (gp[2] & gp[1] & gp[0] & gc[0]);
        assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                     | (gp[3] & gp[2] & gp[1] & gg[0])
                     | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
        assign x[4*j +: 4] = gp ^ gc[3:0];
        assign c[j+1] = gc[4];
    end
    // zero padding above W turns the carry out of bit W-1 into sum bit W
    assign s = (W + 1)'({c[G], x});
endmodule

module multi_operand_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int NUM_OPS = 4,
    parameter int SAT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*NUM_OPS-1:0] ops,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         sum,
    output logic                     ovf
);
    localparam int L = $clog2(NUM_OPS);
    localparam int FW = WIDTH + L;
    logic adv;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    genvar l, k;
    // lv[0] is the operand set; lv[1..L-1] are the intermediate register stages
    for (l = 0; l < L; l++) begin : lv
        localparam int N = NUM_OPS >> l;
        localparam int W = WIDTH + l;
        logic [W-1:0] d [N];
        logic v;
        if (l == 0) begin : src
            for (k = 0; k < N; k++) begin : op
                assign d[k] = ops[k*WIDTH +: WIDTH];
            end
            assign v = in_valid;
        end else begin : stg
            logic [W-1:0] s [N];
            for (k = 0; k < N; k++) begin : add
                multi_operand_cla_pipe_add #(.W(W - 1)) u_add (
                    .a  (lv[l-1].d[2*k]),
                    .b  (lv[l-1].d[2*k+1]),
                    .ci ((l == 1 && k == 0) ? cin : 1'b0),
                    .s  (s[k])
                );
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    d <= '{default: '0};
                end else if (adv) begin
                    v <= lv[l-1].v;
                    if (lv[l-1].v) d <= s;
                end
            end
        end
    end
    logic [FW-1:0] t;
    logic t_ovf;
    multi_operand_cla_pipe_add #(.W(FW - 1)) u_fin (
        .a  (lv[L-1].d[0]),
        .b  (lv[L-1].d[1]),
        .ci ((L == 1) ? cin : 1'b0),
        .s  (t)
    );
    assign t_ovf = |t[FW-1:WIDTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum <= '0;
            ovf <= 1'b0;
        end else if (adv) begin
            out_valid <= lv[L-1].v;
            if (lv[L-1].v) begin
                ovf <= t_ovf;
                sum <= (SAT != 0 && t_ovf) ? '1 : t[WIDTH-1:0];
            end
        end
    end
endmodule

// File: doc/multi_operand_cla_pipe.md
MULTI_OPERAND_CLA_PIPE -- requirements
Module: multi_operand_cla_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter NUM_OPS, default 4, operand count; SHALL be a power of two, 2..8.
REQ-003 Parameter SAT, default 0: 0 = wrap result, 1 = saturate result to all-ones on overflow.
REQ-004 Ports SHALL be as follows:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts the operand set this cycle.
- ops  input  WIDTH*NUM_OPS  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- cin  input  1  carry-in added once into the total; sampled with ops.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- ovf  output  1  true total did not fit in WIDTH bits.
REQ-005 Clocking and reset SHALL be: one clock, clk; reset rst_n, asynchronous assert, active-low.

Function
REQ-006 Every adder SHALL be built from 4-bit carry-lookahead groups (p=a^b, g=a&b, group carries from g/p terms), with group carry-out rippling into the next group.
REQ-007 The block SHALL be a balanced adder tree of L = log2(NUM_OPS) levels, with one register stage after each level.
REQ-008 Latency SHALL be L cycles from the accepting edge to out_valid (2 cycles at NUM_OPS=4).
REQ-009 Each level SHALL widen its partial sums by 1 bit, so no carry is lost inside the tree; the final internal width is WIDTH+L.
REQ-010 cin SHALL enter as carry-in of the level-1 adder for operands 0/1 only; all other adders have carry-in 0.
REQ-011 Result rules, with T = full-precision total:
- ovf = (T >= 2^WIDTH).
- SAT=0: sum = T mod 2^WIDTH.
- SAT=1: sum = all-ones when ovf=1, otherwise T.
REQ-012 Pipeline advance enable SHALL be adv = !out_valid || out_ready; in_ready = adv, combinationally.
REQ-013 On adv=1, every stage SHALL shift forward one step, each with its own valid bit. The stage-1 valid bit loads in_valid. On adv=0, all stages SHALL hold data and valid unchanged.
REQ-014 A transfer SHALL occur only when in_valid && in_ready. Bubbles (invalid stages) propagate and are not collapsed.
REQ-015 The block SHALL support one accepted operand set per cycle in steady state with out_ready held high.
REQ-016 sum and ovf SHALL be registered outputs and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 ops and cin SHALL be ignored whenever in_valid=0 or in_ready=0.
REQ-018 Result order SHALL equal acceptance order; there is no reordering and no drop.

Reset
REQ-019 While rst_n=0: out_valid=0, sum=0, ovf=0, and all stage valid bits and data registers are 0; in_ready=1.
REQ-020 Assertion of rst_n mid-operation SHALL discard all in-flight sets immediately (asynchronous). No result emerges for them after release.
REQ-021 The first accept after release SHALL be possible on the first rising edge with rst_n=1.

Verification (WIDTH=16, NUM_OPS=4, out_ready=1 unless stated)
REQ-022 Basic latency and throughput:
- Stimulus: ops={896,224,224,56}, cin=0, then {896,224,1,14} on the next cycle.
- Response: sum=1400, ovf=0 two cycles after the first accept; sum=1135 on the following cycle.
REQ-023 Carry-in path:
- Stimulus: ops={896,224,0,999}, cin=1.
- Response: sum=2120, ovf=0.
REQ-024 Overflow, both modes:
- Stimulus: ops={0,0,1,0xFFFF}, cin=0.
- Response SAT=0: sum=0x0000, ovf=1.
- Response SAT=1: sum=0xFFFF, ovf=1.
- Stimulus: all four operands 0xFFFF, cin=1.
- Response SAT=0: sum=0xFFFD, ovf=1.
REQ-025 Backpressure:
- Stimulus: three back-to-back sets (5+0+224+896 etc.), with out_ready=0 for 4 cycles once out_valid rises.
- Response: in_ready=0 and sum held at 1125 throughout the stall; all three results appear in order after release with none lost or duplicated.
REQ-026 Reset mid-flight:
- Stimulus: accept two sets, then pulse rst_n low for 1 cycle before either emerges.
- Response: out_valid=0, sum=0 immediately; no stale result appears afterwards; the next accepted set yields the correct sum after 2 cycles.
REQ-027 Parameter sweep:
- Stimulus: random ops at NUM_OPS=2, 8 and WIDTH=4, 32.
- Response: sum and ovf match the reference model per REQ-011; latency equals log2(NUM_OPS).
